// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot TDM receiver that rebuilds four parallel channels from one serial stream.
// Define TDM_FLYWHEEL_EN to ride through up to SYNC_MISS_MAX consecutive missing syncs while locked.
module tdm_demux4 #(
  parameter int unsigned W = 1
`ifdef TDM_FLYWHEEL_EN
  ,
  parameter int unsigned SYNC_MISS_MAX = 2
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         sync,
  output logic [W-1:0] O0,
  output logic [W-1:0] O1,
  output logic [W-1:0] O2,
  output logic [W-1:0] O3,
  output logic [1:0]   S,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err
);

  typedef enum logic [0:0] {StHunt, StLock} state_e;

  state_e       state;
  logic [W-1:0] shadow0, shadow1, shadow2;

`ifdef TDM_FLYWHEEL_EN
  localparam int unsigned MissW = (SYNC_MISS_MAX < 1) ? 1 : $clog2(SYNC_MISS_MAX + 1);
  logic [MissW-1:0] miss_cnt;
`endif

  assign locked = (state == StLock);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StHunt;
      S           <= 2'd0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      O0          <= '0;
      O1          <= '0;
      O2          <= '0;
      O3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_FLYWHEEL_EN
      miss_cnt    <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (en) begin
        unique case (state)
          StHunt: begin
            if (sync) begin
              shadow0 <= din;
              S       <= 2'd1;
              state   <= StLock;
            end
          end
          StLock: begin
            if (sync) begin
              // Any sync restarts the frame; mid-frame it drops the partial frame.
              shadow0 <= din;
              S       <= 2'd1;
              if (S != 2'd0) begin
                sync_err <= 1'b1;
              end
`ifdef TDM_FLYWHEEL_EN
              else begin
                miss_cnt <= '0;
              end
`endif
            end else begin
              unique case (S)
                2'd0: begin
                  sync_err <= 1'b1;
`ifdef TDM_FLYWHEEL_EN
                  if (miss_cnt == MissW'(SYNC_MISS_MAX)) begin
                    state    <= StHunt;
                    miss_cnt <= '0;
                  end else begin
                    miss_cnt <= miss_cnt + 1'b1;
                    shadow0  <= din;
                    S        <= 2'd1;
                  end
`else
                  state <= StHunt;
`endif
                end
                2'd1: begin
                  shadow1 <= din;
                  S       <= 2'd2;
                end
                2'd2: begin
                  shadow2 <= din;
                  S       <= 2'd3;
                end
                2'd3: begin
                  // Commit all four channels at once; slot 3 bypasses the shadows.
                  O0          <= shadow0;
                  O1          <= shadow1;
                  O2          <= shadow2;
                  O3          <= din;
                  frame_valid <= 1'b1;
                  S           <= 2'd0;
                end
                default: ;
              endcase
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4; committed frames are scoreboarded in a queue.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [0:0] din;
  logic       sync;
  logic [0:0] O0, O1, O2, O3;
  logic [1:0] S;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  int         vectors = 0;
  int         miscompares = 0;
  int         n_pushed = 0;
  int         n_frames = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_o = 4'h0;
  logic       mon_on = 1'b0;

  tdm_demux4 #(.W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .sync       (sync),
    .O0         (O0),
    .O1         (O1),
    .O2         (O2),
    .O3         (O3),
    .S          (S),
    .frame_valid(frame_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs must hold the last scoreboarded frame, changing only on a frame_valid cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_valid", 32'd1, 32'd0);
        end else begin
          cur_o = exp_q.pop_front();
          n_frames++;
        end
      end
      chk("O0..O3", {28'd0, O0, O1, O2, O3}, {28'd0, cur_o});
    end
  end

  task automatic tick(input logic e, input logic d, input logic sy, input logic [1:0] exp_s,
                      input logic exp_err, input logic exp_lock);
    en   = e;
    din  = d;
    sync = sy;
    @(posedge clk);
    @(negedge clk);
    chk("S", {30'd0, S}, {30'd0, exp_s});
    chk("sync_err", {31'd0, sync_err}, {31'd0, exp_err});
    chk("locked", {31'd0, locked}, {31'd0, exp_lock});
  endtask

  // f = {slot0, slot1, slot2, slot3}
  task automatic frame(input logic [3:0] f, input logic sy0, input logic err0);
    tick(1'b1, f[3], sy0, 2'd1, err0, 1'b1);
    tick(1'b1, f[2], 1'b0, 2'd2, 1'b0, 1'b1);
    tick(1'b1, f[1], 1'b0, 2'd3, 1'b0, 1'b1);
    exp_q.push_back(f);
    n_pushed++;
    tick(1'b1, f[0], 1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    rst_n  = 1'b0;
    en     = 1'b1;
    din    = 1'b1;
    sync   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    sync  = 1'b0;
    chk("rst_O", {28'd0, O0, O1, O2, O3}, 32'd0);
    chk("rst_S", {30'd0, S}, 32'd0);
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
    cur_o  = 4'h0;
    mon_on = 1'b1;
  endtask

  initial begin
    logic [3:0] f;
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    sync  = 1'b0;
    do_reset();

    // Unsynced words in HUNT are discarded.
    tick(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

    // Single frame, then two back-to-back frames.
    frame(4'b1000, 1'b1, 1'b0);
    frame(4'b0101, 1'b1, 1'b0);
    frame(4'b1010, 1'b1, 1'b0);

    // en gaps of two cycles after every slot; S must hold while en is low.
    f = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        exp_q.push_back(f);
        n_pushed++;
      end
      tick(1'b1, f[3-i], (i == 0), 2'((i + 1) % 4), 1'b0, 1'b1);
      repeat (2) tick(1'b0, 1'b1, 1'b1, 2'((i + 1) % 4), 1'b0, 1'b1);
    end

    // Early sync at slot 2 drops the partial frame and restarts from that word.
    frame(4'b1001, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    exp_q.push_back(4'b1010);
    n_pushed++;
    tick(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Missing sync at slot 0.
`ifdef TDM_FLYWHEEL_EN
    frame(4'b1100, 1'b0, 1'b1);
    frame(4'b0110, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
`else
    tick(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
`endif
    tick(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    frame(4'b1110, 1'b1, 1'b0);

    // Reset at slot 2 discards the partial frame.
    tick(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    do_reset();
    frame(4'b0110, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

    chk("frames_outstanding", exp_q.size(), 32'd0);
    chk("frame_count", n_frames, n_pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
